// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: two writeback sources (ALU, load) each feed a
// small FIFO; a round-robin arbiter drains one head per cycle into a
// registered write stage. A scoreboard reports in-flight writes to RA/RB.
module regfile_write_arbiter #(
   parameter int DEPTH    = 2,
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req0Valid,
   output logic              Req0Ready,
   input  logic [ADDR_W-1:0] Req0RW,
   input  logic [DATA_W-1:0] Req0Data,
   input  logic              Req1Valid,
   output logic              Req1Ready,
   input  logic [ADDR_W-1:0] Req1RW,
   input  logic [DATA_W-1:0] Req1Data,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   output logic              PendA,
   output logic              PendB,
   output logic              RegWr,
   output logic [ADDR_W-1:0] RW,
   output logic [DATA_W-1:0] BusW,
   output logic              Idle
);

   localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
   localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(DEPTH);

   // Stage p0: per-source FIFO storage and occupancy
   logic [ADDR_W-1:0] rwMem_p0   [2][DEPTH];
   logic [DATA_W-1:0] dataMem_p0 [2][DEPTH];
   logic [PTR_W-1:0]  rdPtr_p0   [2];
   logic [PTR_W-1:0]  wrPtr_p0   [2];
   logic [PTR_W:0]    count_p0   [2];
   logic              rrPtr_p0;

   logic [ADDR_W-1:0] reqRw   [2];
   logic [DATA_W-1:0] reqData [2];
   logic [1:0]        reqValid;
   logic [1:0]        reqReady;
   logic [1:0]        push;
   logic [1:0]        notEmpty;
   logic [1:0]        grant;
   logic              grantSrc;
   logic [ADDR_W-1:0] headRw;
   logic [DATA_W-1:0] headData;

   // Stage p1: registered register-file write port
   logic              regWr_p1;
   logic [ADDR_W-1:0] rw_p1;
   logic [DATA_W-1:0] busW_p1;

   // Gather both sources into arrays; Ready depends on occupancy only
   always_comb begin
      reqRw[0]   = Req0RW;
      reqRw[1]   = Req1RW;
      reqData[0] = Req0Data;
      reqData[1] = Req1Data;
      reqValid   = {Req1Valid, Req0Valid};
      for (int s = 0; s < 2; s++) begin
         notEmpty[s] = (count_p0[s] != '0);
         reqReady[s] = !Reset && (count_p0[s] != FULL_CNT);
         push[s]     = reqValid[s] && reqReady[s];
      end
   end

   assign Req0Ready = reqReady[0];
   assign Req1Ready = reqReady[1];

   // Round-robin grant: a lone non-empty FIFO wins, otherwise the pointer source wins
   always_comb begin
      grant = '0;
      if (notEmpty[0] && notEmpty[1]) begin
         grant[rrPtr_p0] = 1'b1;
      end else begin
         grant = notEmpty;
      end
      grantSrc = grant[1];
      headRw   = rwMem_p0[grantSrc][rdPtr_p0[grantSrc]];
      headData = dataMem_p0[grantSrc][rdPtr_p0[grantSrc]];
   end

   // FIFO payload storage; contents are meaningless unless counted as occupied
   always_ff @(posedge Clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push[s]) begin
            rwMem_p0[s][wrPtr_p0[s]]   <= reqRw[s];
            dataMem_p0[s][wrPtr_p0[s]] <= reqData[s];
         end
      end
   end

   // FIFO pointers/occupancy and the round-robin pointer
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int s = 0; s < 2; s++) begin
            rdPtr_p0[s] <= '0;
            wrPtr_p0[s] <= '0;
            count_p0[s] <= '0;
         end
         rrPtr_p0 <= 1'b0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s]) wrPtr_p0[s] <= wrPtr_p0[s] + PTR_W'(1);
            if (grant[s]) rdPtr_p0[s] <= rdPtr_p0[s] + PTR_W'(1);
            case ({push[s], grant[s]})
               2'b10:   count_p0[s] <= count_p0[s] + (PTR_W+1)'(1);
               2'b01:   count_p0[s] <= count_p0[s] - (PTR_W+1)'(1);
               default: count_p0[s] <= count_p0[s];
            endcase
         end
         // Any grant, lone or contended, hands the next turn to the other source
         if (|grant) rrPtr_p0 <= ~grantSrc;
      end
   end

   // Write stage: zero-register writes consume the grant but never assert RegWr
   always_ff @(posedge Clk) begin
      if (Reset) begin
         regWr_p1 <= 1'b0;
         rw_p1    <= '0;
         busW_p1  <= '0;
      end else begin
         regWr_p1 <= (|grant) && (headRw != ZERO_ADDR);
         if (|grant) begin
            rw_p1   <= headRw;
            busW_p1 <= headData;
         end
      end
   end

   assign RegWr = regWr_p1;
   assign RW    = rw_p1;
   assign BusW  = busW_p1;
   assign Idle  = !notEmpty[0] && !notEmpty[1] && !regWr_p1;

   // Scoreboard: match RA/RB against every occupied FIFO entry and the live write
   always_comb begin
      logic hitA;
      logic hitB;
      hitA = regWr_p1 && (rw_p1 == RA);
      hitB = regWr_p1 && (rw_p1 == RB);
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if ((PTR_W+1)'(k) < count_p0[s]) begin
               if (rwMem_p0[s][rdPtr_p0[s] + PTR_W'(k)] == RA) hitA = 1'b1;
               if (rwMem_p0[s][rdPtr_p0[s] + PTR_W'(k)] == RB) hitB = 1'b1;
            end
         end
      end
      PendA = hitA && (RA != ZERO_ADDR);
      PendB = hitB && (RB != ZERO_ADDR);
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_regfile_write_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Req0Valid, Req1Valid;
   logic        Req0Ready, Req1Ready;
   logic [4:0]  Req0RW, Req1RW;
   logic [63:0] Req0Data, Req1Data;
   logic [4:0]  RA, RB;
   logic        PendA, PendB;
   logic        RegWr;
   logic [4:0]  RW;
   logic [63:0] BusW;
   logic        Idle;

   int tests = 0;
   int fails = 0;

   regfile_write_arbiter #(.DEPTH(2), .DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
      .Clk(Clk), .Reset(Reset),
      .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0RW(Req0RW), .Req0Data(Req0Data),
      .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1RW(Req1RW), .Req1Data(Req1Data),
      .RA(RA), .RB(RB), .PendA(PendA), .PendB(PendB),
      .RegWr(RegWr), .RW(RW), .BusW(BusW), .Idle(Idle)
   );

   // Free-running clock, period 10
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset = 1'b1;
      Req0Valid = 1'b0; Req0RW = '0; Req0Data = '0;
      Req1Valid = 1'b0; Req1RW = '0; Req1Data = '0;
      RA = '0; RB = '0;
      tick();
      tick();

      // Reset state
      check("rst_RegWr", RegWr, 0);
      check("rst_RW", RW, 0);
      check("rst_BusW", BusW, 0);
      check("rst_Idle", Idle, 1);
      check("rst_Ready0", Req0Ready, 0);
      check("rst_Ready1", Req1Ready, 0);
      Reset = 1'b0;
      #1;
      check("rel_Ready0", Req0Ready, 1);

      // Single ALU write, latency one cycle
      Req0Valid = 1'b1; Req0RW = 5'd5; Req0Data = 64'hDEAD_BEEF;
      RA = 5'd5; RB = 5'd6;
      tick();
      check("t1_e1_RegWr", RegWr, 0);
      check("t1_e1_PendA", PendA, 1);
      check("t1_e1_PendB", PendB, 0);
      check("t1_e1_Idle", Idle, 0);
      Req0Valid = 1'b0;
      tick();
      check("t1_e2_RegWr", RegWr, 1);
      check("t1_e2_RW", RW, 5);
      check("t1_e2_BusW", BusW, 64'hDEAD_BEEF);
      check("t1_e2_PendA", PendA, 1);
      tick();
      check("t1_e3_RegWr", RegWr, 0);
      check("t1_e3_PendA", PendA, 0);
      check("t1_e3_Idle", Idle, 1);

      // Reset pulse to return the round-robin pointer to source 0
      Reset = 1'b1;
      tick();
      Reset = 1'b0;

      // Both sources streaming: interleaved writes and Ready backpressure
      Req0Valid = 1'b1; Req0RW = 5'd1;  Req0Data = 64'h101;
      Req1Valid = 1'b1; Req1RW = 5'd11; Req1Data = 64'h111;
      RA = 5'd13; RB = 5'd3;
      tick();
      check("t2_e1_RegWr", RegWr, 0);
      check("t2_e1_Ready0", Req0Ready, 1);
      check("t2_e1_Ready1", Req1Ready, 1);
      check("t2_e1_PendA", PendA, 0);
      Req0RW = 5'd2;  Req0Data = 64'h102;
      Req1RW = 5'd12; Req1Data = 64'h112;
      tick();
      check("t2_e2_RegWr", RegWr, 1);
      check("t2_e2_RW", RW, 1);
      check("t2_e2_BusW", BusW, 64'h101);
      check("t2_e2_Ready0", Req0Ready, 1);
      check("t2_e2_Ready1", Req1Ready, 0);
      Req0RW = 5'd3;  Req0Data = 64'h103;
      Req1RW = 5'd13; Req1Data = 64'h113;
      tick();
      check("t2_e3_RegWr", RegWr, 1);
      check("t2_e3_RW", RW, 11);
      check("t2_e3_BusW", BusW, 64'h111);
      check("t2_e3_Ready0", Req0Ready, 0);
      check("t2_e3_Ready1", Req1Ready, 1);
      check("t2_e3_PendB", PendB, 1);
      Req0Valid = 1'b0;
      tick();
      check("t2_e4_RegWr", RegWr, 1);
      check("t2_e4_RW", RW, 2);
      check("t2_e4_Ready1", Req1Ready, 0);
      check("t2_e4_PendA", PendA, 1);
      Req1Valid = 1'b0;
      tick();
      check("t2_e5_RegWr", RegWr, 1);
      check("t2_e5_RW", RW, 12);
      tick();
      check("t2_e6_RegWr", RegWr, 1);
      check("t2_e6_RW", RW, 3);
      check("t2_e6_BusW", BusW, 64'h103);
      tick();
      check("t2_e7_RegWr", RegWr, 1);
      check("t2_e7_RW", RW, 13);
      check("t2_e7_PendA", PendA, 1);
      tick();
      check("t2_e8_RegWr", RegWr, 0);
      check("t2_e8_Idle", Idle, 1);
      check("t2_e8_PendA", PendA, 0);

      // Zero-register write: accepted, dropped, never pending
      Req0Valid = 1'b1; Req0RW = 5'd31; Req0Data = 64'h1;
      RA = 5'd31;
      tick();
      check("t4_e1_Ready0", Req0Ready, 1);
      check("t4_e1_PendA", PendA, 0);
      check("t4_e1_RegWr", RegWr, 0);
      Req0Valid = 1'b0;
      tick();
      check("t4_e2_RegWr", RegWr, 0);
      check("t4_e2_RW", RW, 31);
      check("t4_e2_BusW", BusW, 64'h1);
      check("t4_e2_Idle", Idle, 1);
      tick();
      check("t4_e3_RegWr", RegWr, 0);

      // Reset with entries in flight: everything discarded
      Req0Valid = 1'b1; Req0RW = 5'd20; Req0Data = 64'hAAAA;
      Req1Valid = 1'b1; Req1RW = 5'd21; Req1Data = 64'hBBBB;
      tick();
      Req0RW = 5'd22; Req0Data = 64'hCCCC;
      Req1RW = 5'd23; Req1Data = 64'hDDDD;
      tick();
      check("t5_pre_RegWr", RegWr, 1);
      Reset = 1'b1;
      tick();
      check("t5_rst_Ready0", Req0Ready, 0);
      check("t5_rst_Ready1", Req1Ready, 0);
      check("t5_rst_RegWr", RegWr, 0);
      check("t5_rst_RW", RW, 0);
      check("t5_rst_BusW", BusW, 0);
      check("t5_rst_Idle", Idle, 1);
      Reset = 1'b0;
      Req0Valid = 1'b0; Req1Valid = 1'b0;
      RA = 5'd22; RB = 5'd23;
      #1;
      check("t5_rel_Ready0", Req0Ready, 1);
      check("t5_rel_Ready1", Req1Ready, 1);
      tick();
      check("t5_a1_RegWr", RegWr, 0);
      check("t5_a1_Idle", Idle, 1);
      check("t5_a1_PendA", PendA, 0);
      check("t5_a1_PendB", PendB, 0);
      check("t5_a1_RW", RW, 0);
      check("t5_a1_BusW", BusW, 0);
      tick();
      check("t5_a2_RegWr", RegWr, 0);
      check("t5_a2_RW", RW, 0);

      // Same destination from both sources on one edge: source 0 first
      Req0Valid = 1'b1; Req0RW = 5'd7; Req0Data = 64'h7A;
      Req1Valid = 1'b1; Req1RW = 5'd7; Req1Data = 64'h7B;
      RA = 5'd7; RB = 5'd7;
      tick();
      check("t6_e1_RegWr", RegWr, 0);
      check("t6_e1_PendA", PendA, 1);
      Req0Valid = 1'b0; Req1Valid = 1'b0;
      tick();
      check("t6_e2_RegWr", RegWr, 1);
      check("t6_e2_RW", RW, 7);
      check("t6_e2_BusW", BusW, 64'h7A);
      check("t6_e2_PendA", PendA, 1);
      tick();
      check("t6_e3_RegWr", RegWr, 1);
      check("t6_e3_BusW", BusW, 64'h7B);
      check("t6_e3_PendB", PendB, 1);
      tick();
      check("t6_e4_RegWr", RegWr, 0);
      check("t6_e4_PendA", PendA, 0);
      check("t6_e4_Idle", Idle, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
